// File: rtl/pipe_pkg.sv
// pipe_pkg: types and constants shared by the pipeline boundary stages
// (IF/OF, OF/EX, EX/MEM).
//   PIPE_PC_W / PIPE_INSTR_W : default payload widths for the stage instances
//   PIPE_NOP_INSTR           : bubble encoding driven when a stage holds nothing
//   PIPE_STAT_W              : width of the optional stall/flush statistics counters
//   pipe_state_e             : occupancy of a skid stage (EMPTY / ONE / FULL)
package pipe_pkg;

  localparam int unsigned PIPE_PC_W    = 32;
  localparam int unsigned PIPE_INSTR_W = 32;
  localparam int unsigned PIPE_STAT_W  = 16;

  localparam logic [31:0] PIPE_NOP_INSTR = 32'h6800_0000;

  // EMPTY: no entry; ONE: main entry valid; FULL: main and skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: free-running event counter that sticks at all-ones.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  asynchronous, active-high reset; clears the count
//   inc_i  in  count one event this cycle
//   cnt_o  out current count (registered), saturates at 2**W-1
module pipe_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Increment unless already at the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: pipeline boundary register carrying {pc, instr} with a
// valid/ready handshake and a 2-entry skid buffer so in_ready can be a flop
// while still sustaining one transfer per cycle.
// Ports:
//   clk, rst           clock (rising edge); asynchronous active-high reset
//   flush_i            drop every held entry and any same-cycle upstream offer
//   in_valid/in_ready  upstream handshake; in_ready is registered
//   in_pc/in_instr     upstream payload
//   out_valid/out_ready downstream handshake; out_ready low stalls the stage
//   out_pc/out_instr   main entry; out_instr is the NOP bubble when empty
// Optional build macro PIPE_SKID_STATS_EN adds:
//   stall_cnt          cycles with out_valid & !out_ready (saturating)
//   flush_cnt          cycles with flush_i asserted (saturating)
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned             PC_W      = PIPE_PC_W,
  parameter int unsigned             INSTR_W   = PIPE_INSTR_W,
  parameter logic [INSTR_W-1:0]      NOP_INSTR = INSTR_W'(PIPE_NOP_INSTR),
  parameter logic [PC_W-1:0]         RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [PIPE_STAT_W-1:0] stall_cnt,
  output logic [PIPE_STAT_W-1:0] flush_cnt
`endif
);

  pipe_state_e        state_q,      state_d;
  logic [PC_W-1:0]    main_pc_q,    main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               out_valid_q,  out_valid_d;
  logic               in_ready_q,   in_ready_d;
  logic [INSTR_W-1:0] out_instr_q,  out_instr_d;

  // Next-state and storage update; flush overrides every transition
  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    unique case (state_q)
      EMPTY: begin
        if (in_valid) begin
          main_pc_d    = in_pc;
          main_instr_d = in_instr;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (in_valid && out_ready) begin
          main_pc_d    = in_pc;
          main_instr_d = in_instr;
        end else if (in_valid) begin
          // Downstream stalled: park the new entry behind main
          skid_pc_d    = in_pc;
          skid_instr_d = in_instr;
          state_d      = FULL;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so nothing is taken from upstream
        if (out_ready) begin
          main_pc_d    = skid_pc_q;
          main_instr_d = skid_instr_q;
          state_d      = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Main keeps its last contents so out_pc stays stable across a flush
    if (flush_i) begin
      state_d      = EMPTY;
      main_pc_d    = main_pc_q;
      main_instr_d = main_instr_q;
      skid_pc_d    = '0;
      skid_instr_d = '0;
    end
  end

  // Registered handshake/output values derived from the next state only
  always_comb begin
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
    out_instr_d = (state_d == EMPTY) ? NOP_INSTR : main_instr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_pc_q    <= RESET_PC;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      out_instr_q  <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      out_instr_q  <= out_instr_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = main_pc_q;
  assign out_instr = out_instr_q;

`ifdef PIPE_SKID_STATS_EN
  logic stall_inc;
  assign stall_inc = out_valid_q & ~out_ready;

  pipe_sat_counter #(.W(PIPE_STAT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  pipe_sat_counter #(.W(PIPE_STAT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_i),
    .cnt_o (flush_cnt)
  );
`endif

endmodule
